// File: rtl/alu_seq.sv
// Issue/writeback sequencer for the 8-bit ALU: owns the 8-entry register file,
// snapshots operands at accept, captures the ALU result and writes it back to rd.
module alu_seq #(
   parameter int DW    = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid,
   input  logic [8:0]       instr,
   output logic             instr_ready,
   output logic [DW-1:0]    alu_input_a,
   output logic [DW-1:0]    alu_input_b,
   output logic [2:0]       alu_opcode,
   input  logic [DW-1:0]    alu_out,
   input  logic             zero,
   output logic             done,
   output logic             zero_flag,
   output logic [CNT_W-1:0] op_count,
   input  logic             host_we,
   input  logic [2:0]       host_waddr,
   input  logic [DW-1:0]    host_wdata,
   input  logic [2:0]       host_raddr,
   output logic [DW-1:0]    host_rdata
);

   // state  | meaning
   // S_IDLE | ready for an instruction; ALU ports hold the last operands
   // S_EXEC | operands on the ALU, result captured at the edge
   // S_WB   | captured result written to rd, done pulses next cycle
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       opc_q, opc_d;
   logic [2:0]       rd_q, rd_d;
   logic [DW-1:0]    op_a_q, op_a_d;
   logic [DW-1:0]    op_b_q, op_b_d;
   logic [DW-1:0]    res_q, res_d;
   logic             zero_q, zero_d;
   logic             zf_q, zf_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    rf_q [8];
   logic [DW-1:0]    rf_d [8];
   logic             wb_en;

   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      rd_d    = rd_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      res_d   = res_q;
      zero_d  = zero_q;
      zf_d    = zf_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      wb_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               opc_d   = instr[8:6];
               rd_d    = instr[5:3];
               op_a_d  = rf_q[instr[5:3]];
               op_b_d  = rf_q[instr[2:0]];
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            res_d   = alu_out;
            zero_d  = zero;
            state_d = S_WB;
         end
         S_WB: begin
            wb_en   = 1'b1;
            zf_d    = zero_q;
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Writeback is applied after the host write so it wins on an rd collision.
   always_comb begin
      for (int i = 0; i < 8; i++) rf_d[i] = rf_q[i];
      if (host_we) rf_d[host_waddr] = host_wdata;
      if (wb_en)   rf_d[rd_q]       = res_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         opc_q   <= '0;
         rd_q    <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         zf_q    <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         rd_q    <= rd_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         zf_q    <= zf_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign alu_input_a = op_a_q;
   assign alu_input_b = op_b_q;
   assign alu_opcode  = opc_q;
   assign done        = done_q;
   assign zero_flag   = zf_q;
   assign op_count    = cnt_q;
   assign host_rdata  = rf_q[host_raddr];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU; CNT_W=2 so the counter wrap is reachable.
module tb_alu_seq;

   localparam int DW    = 8;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             instr_valid;
   logic [8:0]       instr;
   logic             instr_ready;
   logic [DW-1:0]    alu_input_a, alu_input_b, alu_out;
   logic [2:0]       alu_opcode;
   logic             zero, done, zero_flag;
   logic [CNT_W-1:0] op_count;
   logic             host_we;
   logic [2:0]       host_waddr, host_raddr;
   logic [DW-1:0]    host_wdata, host_rdata;

   int n_chk = 0;
   int n_err = 0;

   alu_seq #(.DW(DW), .CNT_W(CNT_W)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .alu_input_a (alu_input_a),
      .alu_input_b (alu_input_b),
      .alu_opcode  (alu_opcode),
      .alu_out     (alu_out),
      .zero        (zero),
      .done        (done),
      .zero_flag   (zero_flag),
      .op_count    (op_count),
      .host_we     (host_we),
      .host_waddr  (host_waddr),
      .host_wdata  (host_wdata),
      .host_raddr  (host_raddr),
      .host_rdata  (host_rdata)
   );

   always #5 clk = ~clk;

   // ALU: 000 AND, 001 ADD, 010 XOR, 011 SLT, 100 SHL, 101 SHR, 110 OR, 111 SUB
   always_comb begin
      alu_out = '0;
      case (alu_opcode)
         3'd0: alu_out = alu_input_a & alu_input_b;
         3'd1: alu_out = alu_input_a + alu_input_b;
         3'd2: alu_out = alu_input_a ^ alu_input_b;
         3'd3: alu_out = (alu_input_a < alu_input_b) ? 8'h01 : 8'h00;
         3'd4: alu_out = alu_input_a << alu_input_b[2:0];
         3'd5: alu_out = alu_input_a >> alu_input_b[2:0];
         3'd6: alu_out = alu_input_a | alu_input_b;
         default: alu_out = alu_input_a - alu_input_b;
      endcase
      zero = (alu_out == '0);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [2:0] a, input logic [7:0] d);
      host_we    = 1'b1;
      host_waddr = a;
      host_wdata = d;
      tick();
      host_we    = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
      host_raddr = a;
      #1;
      check_eq(tag, host_rdata, exp);
   endtask

   // Accepts one instruction and waits (bounded) for done; returns in the done cycle.
   task automatic issue(input logic [8:0] ins);
      int lat;
      check_eq("ready_idle", instr_ready, 1);
      instr_valid = 1'b1;
      instr       = ins;
      tick();
      instr_valid = 1'b0;
      check_eq("ready_exec", instr_ready, 0);
      check_eq("opc_exec", alu_opcode, ins[8:6]);
      lat = 99;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (done) begin
            lat = i;
            break;
         end
      end
      check_eq("done_latency", lat, 2);
   endtask

   initial begin
      int  acc_edge [2];
      int  n_acc;
      int  low_cnt;
      int  done_seen;
      bit  rdy;
      logic [1:0] exp_cnt [5];
      logic [7:0] exp_r1;

      reset = 1'b1; instr_valid = 1'b0; instr = '0;
      host_we = 1'b0; host_waddr = '0; host_wdata = '0; host_raddr = '0;
      tick(); tick();
      reset = 1'b0;

      check_eq("rst_ready", instr_ready, 1);
      check_eq("rst_done", done, 0);
      check_eq("rst_zf", zero_flag, 0);
      check_eq("rst_cnt", op_count, 0);
      check_eq("rst_alu_a", alu_input_a, 0);
      check_eq("rst_alu_b", alu_input_b, 0);
      check_eq("rst_opc", alu_opcode, 0);
      check_reg("rst_r0", 3'd0, 8'h00);
      check_reg("rst_r5", 3'd5, 8'h00);
      tick();
      check_eq("idle_hold_ready", instr_ready, 1);

      // ADD R1=0x0F + R2=0xF1 wraps to zero
      host_write(3'd1, 8'h0F);
      host_write(3'd2, 8'hF1);
      issue(9'b001_001_010);
      check_reg("add_r1", 3'd1, 8'h00);
      check_reg("add_r2", 3'd2, 8'hF1);
      check_eq("add_zf", zero_flag, 1);
      check_eq("add_cnt", op_count, 1);
      check_eq("add_alu_a_hold", alu_input_a, 8'h0F);
      tick();
      check_eq("done_pulse_width", done, 0);

      // SLT both ways
      host_write(3'd3, 8'h05);
      host_write(3'd4, 8'h09);
      issue(9'b011_011_100);
      check_reg("slt1_r3", 3'd3, 8'h01);
      check_eq("slt1_zf", zero_flag, 0);
      check_eq("slt1_cnt", op_count, 2);
      tick();
      issue(9'b011_100_011);
      check_reg("slt2_r4", 3'd4, 8'h00);
      check_eq("slt2_zf", zero_flag, 1);
      check_eq("slt2_cnt", op_count, 3);
      tick();

      // Back-to-back XOR then SHL with instr_valid held high
      host_write(3'd5, 8'hA5);
      host_write(3'd6, 8'h01);
      host_write(3'd7, 8'h03);
      n_acc = 0; low_cnt = 0;
      acc_edge[0] = 0; acc_edge[1] = 0;
      instr_valid = 1'b1;
      instr       = 9'b010_101_101;
      for (int c = 1; c <= 12 && n_acc < 2; c++) begin
         rdy = instr_ready;
         tick();
         if (rdy) begin
            acc_edge[n_acc] = c;
            n_acc++;
            if (n_acc == 1) instr = 9'b100_110_111;
            else            instr_valid = 1'b0;
         end else if (n_acc == 1) begin
            low_cnt++;
         end
      end
      instr_valid = 1'b0;
      check_eq("b2b_accepts", n_acc, 2);
      check_eq("b2b_gap", acc_edge[1] - acc_edge[0], 3);
      check_eq("b2b_ready_low", low_cnt, 2);
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) begin
            done_seen = 1;
            break;
         end
      end
      check_eq("b2b_done", done_seen, 1);
      check_reg("b2b_r5", 3'd5, 8'h00);
      check_reg("b2b_r6", 3'd6, 8'h08);
      check_eq("b2b_zf", zero_flag, 0);
      check_eq("b2b_cnt", op_count, 1);
      tick();

      // AND with host writes in EXEC (snapshot) and on the WB edge (collision)
      host_write(3'd2, 8'hFF);
      host_write(3'd3, 8'h3C);
      check_eq("col_ready", instr_ready, 1);
      instr_valid = 1'b1;
      instr       = 9'b000_010_011;
      tick();
      instr_valid = 1'b0;
      host_we = 1'b1; host_waddr = 3'd3; host_wdata = 8'h00;
      tick();
      host_waddr = 3'd2; host_wdata = 8'h77;
      tick();
      host_we = 1'b0;
      check_eq("col_done", done, 1);
      check_reg("col_r2", 3'd2, 8'h3C);
      check_reg("col_r3", 3'd3, 8'h00);
      check_eq("col_zf", zero_flag, 0);
      check_eq("col_cnt", op_count, 2);
      tick();

      // Reset mid-EXEC, with a host write in the reset cycle
      host_write(3'd1, 8'h03);
      host_write(3'd2, 8'h04);
      instr_valid = 1'b1;
      instr       = 9'b001_001_010;
      tick();
      instr_valid = 1'b0;
      reset = 1'b1;
      host_we = 1'b1; host_waddr = 3'd7; host_wdata = 8'h55;
      tick();
      reset = 1'b0;
      host_we = 1'b0;
      check_eq("mid_rst_ready", instr_ready, 1);
      check_eq("mid_rst_done", done, 0);
      check_eq("mid_rst_cnt", op_count, 0);
      check_eq("mid_rst_alu_a", alu_input_a, 0);
      check_eq("mid_rst_opc", alu_opcode, 0);
      done_seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done) done_seen = 1;
      end
      check_eq("mid_rst_no_done", done_seen, 0);
      check_eq("mid_rst_cnt_hold", op_count, 0);
      for (int r = 0; r < 8; r++) check_reg("mid_rst_reg", 3'(r), 8'h00);

      // Counter wrap with CNT_W=2: R1 doubles each time
      exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
      exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
      host_write(3'd1, 8'h01);
      exp_r1 = 8'h01;
      for (int k = 0; k < 5; k++) begin
         issue(9'b001_001_001);
         exp_r1 = exp_r1 << 1;
         check_eq("wrap_cnt", op_count, exp_cnt[k]);
         check_reg("wrap_r1", 3'd1, exp_r1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle issue/writeback sequencer that drives the 8-bit ALU from the initiator side. It accepts 9-bit register-register instructions over a valid/ready handshake and reads both operands from an internal 8-entry register file. It presents them with the 3-bit opcode to the combinational ALU, captures `alu_out` and `zero`, and writes the result back. It sits between the instruction source (fetch logic or testbench) and the ALU, and owns the architectural register file.

## Interface
- `DW`, 8: datapath/register width; only 8 is supported by the ALU.
- `CNT_W`, 16: width of the completed-operation counter.

- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `instr_valid` in 1: instruction present on `instr`.
- `instr` in 9: [8:6] ALU opcode, [5:3] rd (dest and operand A), [2:0] rs (operand B).
- `instr_ready` out 1: sequencer can accept; high only in IDLE.
- `alu_input_a` out DW: operand A to ALU.
- `alu_input_b` out DW: operand B to ALU.
- `alu_opcode` out 3: opcode to ALU.
- `alu_out` in DW: ALU result, combinational from the above.
- `zero` in 1: ALU zero flag.
- `done` out 1: one-cycle pulse; the writeback of the current instruction has landed.
- `zero_flag` out 1: `zero` captured from the last completed instruction.
- `op_count` out CNT_W: number of completed instructions, wraps modulo 2^CNT_W.
- `host_we` in 1: host register write enable.
- `host_waddr` in 3, `host_wdata` in DW: host write address and data.
- `host_raddr` in 3, `host_rdata` out DW: combinational host read port.

## Operation
- States: IDLE, EXEC, WB.
- **IDLE**
  - `instr_ready`=1.
  - When `instr_valid` is high, the rising edge latches opcode, rd, `R[rd]` into `op_a_q` and `R[rs]` into `op_b_q`, then moves to EXEC.
- **EXEC**
  - `alu_input_a`=`op_a_q`, `alu_input_b`=`op_b_q`, `alu_opcode`=latched opcode.
  - The edge captures `alu_out` into `res_q` and `zero` into `zero_q`, then moves to WB.
- **WB**
  - The edge writes `R[rd]`←`res_q` and `zero_flag`←`zero_q`, increments `op_count`, sets `done` to 1 for the next cycle, and moves to IDLE.
- ALU ports are driven from the latched registers in every state.
  - They hold the last instruction's values in IDLE.
  - After reset they are 0.
- The sequencer never interprets the opcode. All 8 opcodes are treated identically and all write rd. Compare ops therefore write 0x01/0x00.
- rd==rs is legal: both operands are the same register value.
- Operands are snapshotted at accept time. Host writes to rd/rs after acceptance do not affect the in-flight result.
- Host write collision: if `host_we` targets `rd` on the WB edge, the writeback wins and the host write is dropped. Host writes to other addresses complete normally in any state.
- `host_rdata` = `R[host_raddr]`, combinational. It reflects writes from the following cycle onward.
- `op_count` wraps from 2^CNT_W−1 to 0 without a flag.

## Timing
- Reset values:
  - state IDLE, `instr_ready`=1, `done`=0, `zero_flag`=0, `op_count`=0.
  - R0..R7=0, all latched operand/opcode/result registers 0.
  - Hence `alu_input_a`=`alu_input_b`=0 and `alu_opcode`=000.
- Latency: accept at edge N → EXEC in cycle N..N+1 → result in `R[rd]` and `done`=1 in the cycle after edge N+2.
- Throughput: one instruction per 3 cycles. A new instruction may be accepted at the edge ending the `done` cycle (edge N+3).
- `instr_valid` low in IDLE: stay IDLE with no state change. `instr` is ignored when `instr_ready`=0.
- Reset asserted in any state, including mid-EXEC or WB:
  - At that edge, return to IDLE with all reset values.
  - No writeback, no `done`, no counter increment.
  - Reset overrides `host_we` in the same cycle.

## Test plan
- **ADD to zero:** preload R1=0x0F, R2=0xF1; issue `instr`=001_001_010 → `done` 3 cycles after accept, R1=0x00, `zero_flag`=1, `op_count`=1.
- **SLT:** preload R3=0x05, R4=0x09; issue 011_011_100 → R3=0x01, `zero_flag`=0. Then issue 011_100_011 → R4=0x00, `zero_flag`=1.
- **Back-to-back:**
  - Hold `instr_valid` high with XOR 010_101_101 (R5=0xA5) followed by SHL 100_110_111 (R6=0x01, R7=0x03).
  - Accepts must be exactly 3 cycles apart; `instr_ready` must be low in EXEC/WB.
  - Expect R5=0x00, R6=0x08.
- **Host collision and snapshot:**
  - Issue AND 000_010_011 with R2=0xFF, R3=0x3C.
  - In EXEC, host writes R3=0x00; on the WB edge, host writes R2=0x77.
  - Expect R2=0x3C (writeback wins) and R3=0x00.
- **Reset mid-operation:** accept ADD and assert `reset` during EXEC → `done` never pulses, `op_count`=0, all registers 0, `instr_ready`=1 in the next cycle.
- **Counter wrap:** use CNT_W=2 and run 5 instructions → `op_count` sequence 1,2,3,0,1.
